ddr_cmd_sched: RTL and testbench

Parametrised command scheduler between the FML port and the CBA async FIFO of the pipelined DDR controller. Tracks open rows across NUM_BANKS banks and enforces per-bank tRCD/tRP and global tRFC in clk cycles. Queues up to AR_MAX refresh requests, refreshes in idle gaps, and forces refresh at saturation. Optional close-page mode issues READ/WRITE with auto-precharge.

---
 rtl/ddr_cmd_sched_pkg.sv | 19 +
 rtl/ddr_cmd_sched_if.sv | 24 ++
 rtl/ddr_cmd_sched_bank_timer.sv | 38 +++
 rtl/ddr_cmd_sched.sv | 132 +++++++++++++
 tb/tb_ddr_cmd_sched.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ddr_cmd_sched_pkg.sv
// ddr_cmd_sched_pkg: DDR command encodings, CBA layout constants, clog2 helper and scheduler states
package ddr_cmd_sched_pkg;
  localparam logic [2:0] DDR_CMD_NOP   = 3'b111;
  localparam logic [2:0] DDR_CMD_ACT   = 3'b011;
  localparam logic [2:0] DDR_CMD_READ  = 3'b101;
  localparam logic [2:0] DDR_CMD_WRITE = 3'b100;
  localparam logic [2:0] DDR_CMD_PRE   = 3'b010;
  localparam logic [2:0] DDR_CMD_AR    = 3'b001;
  localparam logic [2:0] DDR_CMD_MRS   = 3'b000;
  localparam int CBA_CMD_W = 3;
  localparam int A10 = 10;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_AR_PRE, S_AR_WAIT, S_AR, S_RFC} state_e;
endpackage

// File: rtl/ddr_cmd_sched_if.sv
// ddr_cmd_sched_if: init, FML, CBA FIFO and refresh-status signals of the command scheduler
interface ddr_cmd_sched_if import ddr_cmd_sched_pkg::*; #(
  parameter int NUM_BANKS = 4,
  parameter int ROW_W = 13,
  parameter int COL_W = 7,
  parameter int AR_MAX = 4
);
  localparam int BA_W = clog2(NUM_BANKS);
  localparam int CBA_W = CBA_CMD_W + BA_W + ROW_W;
  localparam int ARP_W = clog2(AR_MAX + 1);
  logic init_done, init_req, init_ack, pulse78;
  logic fml_rd, fml_wr, fml_done, cba_full, cba_we, ar_overflow;
  logic [CBA_W-1:0] init_cba, cba_din;
  logic [ROW_W+BA_W+COL_W-1:0] fml_adr;
  logic [ARP_W-1:0] ar_pending;
  modport master (
    output init_done, init_req, init_cba, pulse78, fml_adr, fml_rd, fml_wr, cba_full,
    input  init_ack, fml_done, cba_we, cba_din, ar_pending, ar_overflow
  );
  modport slave (
    input  init_done, init_req, init_cba, pulse78, fml_adr, fml_rd, fml_wr, cba_full,
    output init_ack, fml_done, cba_we, cba_din, ar_pending, ar_overflow
  );
endinterface

// File: rtl/ddr_cmd_sched_bank_timer.sv
// ddr_bank_timer: one bank's open-row state and command-spacing down-counter
module ddr_bank_timer import ddr_cmd_sched_pkg::*; #(
  parameter int ROW_W = 13,
  parameter int T_RCD = 2,
  parameter int T_RP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             act_i,
  input  logic             pre_i,
  input  logic [ROW_W-1:0] row_i,
  output logic             active_o,
  output logic             ready_o,
  output logic [ROW_W-1:0] row_o
);
  localparam int TW = clog2((T_RCD > T_RP ? T_RCD : T_RP) + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic active_q, active_d;
  logic [ROW_W-1:0] row_q, row_d;
  always_comb begin
    tmr_d = act_i ? TW'(T_RCD - 1) : pre_i ? TW'(T_RP - 1) : tmr_q - TW'(tmr_q != '0);
    active_d = act_i | (active_q & ~pre_i);
    row_d = act_i ? row_i : row_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tmr_q <= '0;
      active_q <= 1'b0;
      row_q <= '0;
    end else begin
      tmr_q <= tmr_d;
      active_q <= active_d;
      row_q <= row_d;
    end
  assign active_o = active_q;
  assign ready_o = tmr_q == '0;
  assign row_o = row_q;
endmodule

// File: rtl/ddr_cmd_sched.sv
// ddr_cmd_sched: open-row tracking DDR command scheduler with tRCD/tRP/tRFC spacing and refresh queue
module ddr_cmd_sched import ddr_cmd_sched_pkg::*; #(
  parameter int NUM_BANKS = 4,
  parameter int ROW_W = 13,
  parameter int COL_W = 7,
  parameter int T_RCD = 2,
  parameter int T_RP = 2,
  parameter int T_RFC = 8,
  parameter int AR_MAX = 4,
  parameter bit CLOSE_PAGE = 0
) (
  input logic clk,
  input logic reset,
  ddr_cmd_sched_if.slave bus
);
  localparam int BA_W = clog2(NUM_BANKS);
  localparam int CBA_W = CBA_CMD_W + BA_W + ROW_W;
  localparam int ARP_W = clog2(AR_MAX + 1);
  localparam int GW = clog2(T_RFC + 1);
  state_e state_q, state_d;
  logic [GW-1:0] gtmr_q, gtmr_d;
  logic [ARP_W-1:0] arp_q, arp_d;
  logic ovf_q, ovf_d, we_q, done_q, done_d, ack_q, ack_d;
  logic [CBA_W-1:0] din_q, din_d, word;
  logic [NUM_BANKS-1:0] act, pre, active, ready;
  logic [ROW_W-1:0] rows [NUM_BANKS];
  logic [ROW_W-1:0] row, col_a;
  logic [BA_W-1:0] ba;
  logic [COL_W-1:0] col;
  logic issue, dec, req, hit, go, fml_ok, full;
  assign {row, ba, col} = bus.fml_adr;
  assign req = bus.fml_rd | bus.fml_wr;
  assign hit = active[ba] && (rows[ba] == row);
  assign go = !bus.cba_full && (gtmr_q == '0);
  assign fml_ok = req && !done_q && ready[ba];
  assign full = arp_q == ARP_W'(AR_MAX);
  assign col_a = ROW_W'({col, 3'b000}) | (ROW_W'(CLOSE_PAGE) << A10);
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ddr_bank_timer #(.ROW_W(ROW_W), .T_RCD(T_RCD), .T_RP(T_RP)) u_tmr (
      .clk(clk), .reset(reset), .act_i(act[b]), .pre_i(pre[b]), .row_i(row),
      .active_o(active[b]), .ready_o(ready[b]), .row_o(rows[b])
    );
  end
  // A request stays asserted during its fml_done cycle, so done_q/ack_q gate re-issue.
  always_comb begin
    state_d = state_q;
    word = '0;
    issue = 1'b0;
    act = '0;
    pre = '0;
    dec = 1'b0;
    ack_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      S_INIT: begin
        if (bus.init_req && !ack_q && go) begin
          issue = 1'b1;
          ack_d = 1'b1;
          word = bus.init_cba;
        end
        if (bus.init_done) state_d = S_IDLE;
      end
      S_IDLE:
        if (full) state_d = S_AR_PRE;
        else if (fml_ok && hit) begin
          issue = go;
          done_d = go;
          pre[ba] = go && CLOSE_PAGE;
          word = {bus.fml_rd ? DDR_CMD_READ : DDR_CMD_WRITE, ba, col_a};
        end else if (arp_q != '0 && !req) state_d = S_AR_PRE;
        else if (fml_ok && active[ba] && !CLOSE_PAGE) begin
          issue = go;
          pre[ba] = go;
          word = {DDR_CMD_PRE, ba, ROW_W'(0)};
        end else if (fml_ok && !active[ba]) begin
          issue = go;
          act[ba] = go;
          word = {DDR_CMD_ACT, ba, row};
        end
      S_AR_PRE:
        if (&ready && go) begin
          issue = 1'b1;
          pre = '1;
          word = {DDR_CMD_PRE, BA_W'(0), {ROW_W{1'b1}}};
          state_d = S_AR_WAIT;
        end
      S_AR_WAIT: if (&ready) state_d = S_AR;
      S_AR:
        if (go) begin
          issue = 1'b1;
          dec = 1'b1;
          word = {DDR_CMD_AR, BA_W'(0), ROW_W'(0)};
          state_d = S_RFC;
        end
      S_RFC: if (gtmr_q == '0) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end
  always_comb begin
    gtmr_d = dec ? GW'(T_RFC - 1) : gtmr_q - GW'(gtmr_q != '0);
    arp_d = (bus.pulse78 && !dec && !full) ? arp_q + ARP_W'(1) :
            (dec && !bus.pulse78) ? arp_q - ARP_W'(1) : arp_q;
    ovf_d = ovf_q | (bus.pulse78 && full);
    din_d = issue ? word : din_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_INIT;
      gtmr_q <= '0;
      arp_q <= '0;
      ovf_q <= 1'b0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      ack_q <= 1'b0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      gtmr_q <= gtmr_d;
      arp_q <= arp_d;
      ovf_q <= ovf_d;
      we_q <= issue;
      done_q <= done_d;
      ack_q <= ack_d;
      din_q <= din_d;
    end
  assign bus.cba_we = we_q;
  assign bus.cba_din = din_q;
  assign bus.fml_done = done_q;
  assign bus.init_ack = ack_q;
  assign bus.ar_pending = arp_q;
  assign bus.ar_overflow = ovf_q;
endmodule

// File: tb/tb_ddr_cmd_sched.sv
// tb_ddr_cmd_sched: directed checks of open-page and close-page scheduling, refresh and reset
module tb_ddr_cmd_sched;
  import ddr_cmd_sched_pkg::*;
  localparam logic [31:0] C_ACT = 32'(DDR_CMD_ACT);
  localparam logic [31:0] C_RD = 32'(DDR_CMD_READ);
  localparam logic [31:0] C_WR = 32'(DDR_CMD_WRITE);
  localparam logic [31:0] C_PRE = 32'(DDR_CMD_PRE);
  localparam logic [31:0] C_AR = 32'(DDR_CMD_AR);
  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;
  int gap;
  int stall_bad;
  logic [31:0] cmd, ba, a;
  always #5 clk = ~clk;
  ddr_cmd_sched_if #(.NUM_BANKS(4), .ROW_W(13), .COL_W(7), .AR_MAX(4)) f1 ();
  ddr_cmd_sched_if #(.NUM_BANKS(8), .ROW_W(13), .COL_W(7), .AR_MAX(4)) f2 ();
  ddr_cmd_sched #(.NUM_BANKS(4), .ROW_W(13), .COL_W(7), .T_RCD(2), .T_RP(2), .T_RFC(8),
    .AR_MAX(4), .CLOSE_PAGE(1'b0)) dut (.clk(clk), .reset(reset), .bus(f1));
  ddr_cmd_sched #(.NUM_BANKS(8), .ROW_W(13), .COL_W(7), .T_RCD(2), .T_RP(2), .T_RFC(8),
    .AR_MAX(4), .CLOSE_PAGE(1'b1)) dut_cp (.clk(clk), .reset(reset), .bus(f2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic next1();
    gap = 0;
    do begin @(negedge clk); gap++; end while (f1.cba_we !== 1'b1 && gap < 40);
    chk("cmd_seen1", 32'(f1.cba_we), 1);
    cmd = 32'(f1.cba_din[17:15]);
    ba = 32'(f1.cba_din[14:13]);
    a = 32'(f1.cba_din[12:0]);
  endtask
  task automatic next2();
    gap = 0;
    do begin @(negedge clk); gap++; end while (f2.cba_we !== 1'b1 && gap < 40);
    chk("cmd_seen2", 32'(f2.cba_we), 1);
    cmd = 32'(f2.cba_din[18:16]);
    ba = 32'(f2.cba_din[15:13]);
    a = 32'(f2.cba_din[12:0]);
  endtask
  initial begin
    {f1.init_done, f1.init_req, f1.pulse78, f1.fml_rd, f1.fml_wr, f1.cba_full} = '0;
    {f2.init_done, f2.init_req, f2.pulse78, f2.fml_rd, f2.fml_wr, f2.cba_full} = '0;
    f1.init_cba = '0;
    f2.init_cba = '0;
    f1.fml_adr = '0;
    f2.fml_adr = '0;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(f1.cba_we), 0);
    chk("rst_din", 32'(f1.cba_din), 0);
    chk("rst_done", 32'(f1.fml_done), 0);
    chk("rst_ack", 32'(f1.init_ack), 0);
    chk("rst_arp", 32'(f1.ar_pending), 0);
    chk("rst_ovf", 32'(f1.ar_overflow), 0);
    reset = 1'b0;
    f1.init_req = 1'b1;
    f1.init_cba = {DDR_CMD_MRS, 2'd0, 13'h0123};
    next1();
    chk("init_gap", gap, 1);
    chk("init_ack", 32'(f1.init_ack), 1);
    chk("init_din", 32'(f1.cba_din), 32'h0123);
    f1.init_req = 1'b0;
    f1.init_done = 1'b1;
    f2.init_done = 1'b1;
    @(negedge clk);
    chk("init_ack_pulse", 32'(f1.init_ack), 0);
    chk("init_we_pulse", 32'(f1.cba_we), 0);
    // open-page read: ACT, then READ T_RCD later
    f1.fml_adr = {13'd5, 2'd2, 7'd3};
    f1.fml_rd = 1'b1;
    next1();
    chk("t1_act_gap", gap, 1);
    chk("t1_act_cmd", cmd, C_ACT);
    chk("t1_act_ba", ba, 2);
    chk("t1_act_a", a, 5);
    next1();
    chk("t1_rd_gap", gap, 2);
    chk("t1_rd_cmd", cmd, C_RD);
    chk("t1_rd_ba", ba, 2);
    chk("t1_rd_a", a, 32'h018);
    chk("t1_done", 32'(f1.fml_done), 1);
    f1.fml_rd = 1'b0;
    @(negedge clk);
    chk("t1_done_pulse", 32'(f1.fml_done), 0);
    chk("t1_we_idle", 32'(f1.cba_we), 0);
    // row miss: PRE, T_RP, ACT, T_RCD, READ
    f1.fml_adr = {13'd9, 2'd2, 7'd1};
    f1.fml_rd = 1'b1;
    next1();
    chk("t2_pre_gap", gap, 1);
    chk("t2_pre_cmd", cmd, C_PRE);
    chk("t2_pre_ba", ba, 2);
    chk("t2_pre_a", a, 0);
    next1();
    chk("t2_act_gap", gap, 2);
    chk("t2_act_cmd", cmd, C_ACT);
    chk("t2_act_a", a, 9);
    next1();
    chk("t2_rd_gap", gap, 2);
    chk("t2_rd_cmd", cmd, C_RD);
    chk("t2_rd_a", a, 32'h008);
    chk("t2_done", 32'(f1.fml_done), 1);
    f1.fml_rd = 1'b0;
    @(negedge clk);
    // FIFO full stalls a row-hit write
    f1.cba_full = 1'b1;
    f1.fml_wr = 1'b1;
    f1.fml_adr = {13'd9, 2'd2, 7'h7f};
    stall_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (f1.cba_we !== 1'b0 || f1.fml_done !== 1'b0) stall_bad++;
    end
    chk("t3_stall", stall_bad, 0);
    f1.cba_full = 1'b0;
    @(negedge clk);
    chk("t3_we", 32'(f1.cba_we), 1);
    chk("t3_cmd", 32'(f1.cba_din[17:15]), C_WR);
    chk("t3_a", 32'(f1.cba_din[12:0]), 32'h3f8);
    chk("t3_done", 32'(f1.fml_done), 1);
    f1.fml_wr = 1'b0;
    @(negedge clk);
    // close-page, 8 banks: every READ needs its own ACT and carries A10
    f2.fml_adr = {13'd7, 3'd5, 7'd2};
    f2.fml_rd = 1'b1;
    next2();
    chk("t5_act1_gap", gap, 1);
    chk("t5_act1_cmd", cmd, C_ACT);
    chk("t5_act1_ba", ba, 5);
    chk("t5_act1_a", a, 7);
    next2();
    chk("t5_rd1_gap", gap, 2);
    chk("t5_rd1_cmd", cmd, C_RD);
    chk("t5_rd1_a", a, 32'h410);
    chk("t5_rd1_done", 32'(f2.fml_done), 1);
    f2.fml_rd = 1'b0;
    @(negedge clk);
    f2.fml_rd = 1'b1;
    next2();
    chk("t5_act2_gap", gap, 1);
    chk("t5_act2_cmd", cmd, C_ACT);
    next2();
    chk("t5_rd2_gap", gap, 2);
    chk("t5_rd2_cmd", cmd, C_RD);
    chk("t5_rd2_a", a, 32'h410);
    f2.fml_rd = 1'b0;
    @(negedge clk);
    chk("t5_no_pre", 32'(f2.cba_we), 0);
    // refresh saturation under continuous row-hit reads
    f1.fml_adr = {13'd9, 2'd2, 7'd4};
    f1.fml_rd = 1'b1;
    repeat (4) begin
      f1.pulse78 = 1'b1;
      @(negedge clk);
    end
    chk("t4_arp4", 32'(f1.ar_pending), 4);
    chk("t4_ovf0", 32'(f1.ar_overflow), 0);
    @(negedge clk);
    f1.pulse78 = 1'b0;
    chk("t4_arp_sat", 32'(f1.ar_pending), 4);
    chk("t4_ovf1", 32'(f1.ar_overflow), 1);
    next1();
    chk("t4_preall_cmd", cmd, C_PRE);
    chk("t4_preall_a", a, 32'h1fff);
    @(negedge clk);
    @(negedge clk);
    f1.pulse78 = 1'b1;
    next1();
    f1.pulse78 = 1'b0;
    chk("t4_ar_gap", gap, 1);
    chk("t4_ar_cmd", cmd, C_AR);
    chk("t4_ar_tick_dec", 32'(f1.ar_pending), 4);
    next1();
    chk("t4_rfc_gap", gap, 10);
    chk("t4_pre2_cmd", cmd, C_PRE);
    chk("t4_pre2_a", a, 32'h1fff);
    next1();
    chk("t4_ar2_gap", gap, 3);
    chk("t4_ar2_cmd", cmd, C_AR);
    chk("t4_ar2_arp", 32'(f1.ar_pending), 3);
    // asynchronous reset while in S_RFC
    reset = 1'b1;
    #1;
    chk("t6_we", 32'(f1.cba_we), 0);
    chk("t6_din", 32'(f1.cba_din), 0);
    chk("t6_done", 32'(f1.fml_done), 0);
    chk("t6_ack", 32'(f1.init_ack), 0);
    chk("t6_arp", 32'(f1.ar_pending), 0);
    chk("t6_ovf", 32'(f1.ar_overflow), 0);
    chk("t6_state", 32'(dut.state_q), 32'(S_INIT));
    f1.fml_rd = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
